// File: rtl/kernel3_gmem_pkg.sv
// Shared definitions for the kernel3 gmem m_axi data-path FIFOs.
//   clog2()         : elaboration-time ceil(log2(n)), n >= 1
//   DEF_*           : default geometry / threshold values
//   OB_DEPTH        : words held after the RAM (output register + 2-entry skid)
package kernel3_gmem_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_AEMPTY_TH  = 2;
  localparam int OB_DEPTH       = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/kernel3_gmem_m_axi_fifo_ram.sv
// Simple dual-port storage array for the gmem FIFO.
//   Write port : we/waddr/din, written on the rising edge.
//   Read port  : raddr is captured when ce & rd_en, dout is the registered
//                array output, so a read costs two edges.
//   ce         : freezes the read-side registers when low (writes are gated
//                by the caller through we).
// A write to the address currently being read returns the new data.
module kernel3_gmem_m_axi_fifo_ram
  import kernel3_gmem_pkg::*;
#(
  parameter string MEM_STYLE  = "auto",
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int    DEPTH      = DEF_DEPTH,
  parameter int    ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  // Unrecognised style strings leave the mapping to the tool default.
  if (MEM_STYLE != "auto" && MEM_STYLE != "block" &&
      MEM_STYLE != "distributed" && MEM_STYLE != "ultra") begin : g_style_default
  end

  (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    raddr_d = raddr_q;
    dout_d  = dout_q;
    if (ce && rd_en) raddr_d = raddr;
    if (ce) dout_d = (we && (waddr == raddr_q)) ? din : mem[raddr_q];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q <= '0;
      dout_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/kernel3_gmem_m_axi_fifo_fwft.sv
// First-word-fall-through FIFO between the gmem AXI R/W channel logic and
// the kernel3 stream ports.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   clk_en          : when low every register holds and handshakes are ignored
//   s_valid/s_ready/s_data : write side, s_ready registered (count < DEPTH)
//   m_valid/m_ready/m_data : FWFT read side, all outputs registered
//   count           : words held anywhere (RAM, read pipe, output stages)
//   almost_full/almost_empty : count >= AFULL_TH / count <= AEMPTY_TH
// Datapath: RAM (registered raddr + dout) -> output queue of OB_DEPTH words
// whose head is m_data. Reads are issued only while the output queue can
// absorb every word already in flight, so m_ready may drop at any time.
module kernel3_gmem_m_axi_fifo_fwft
  import kernel3_gmem_pkg::*;
#(
  parameter string MEM_STYLE  = "auto",
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int    DEPTH      = DEF_DEPTH,
  parameter int    ADDR_WIDTH = clog2(DEPTH),
  parameter int    AFULL_TH   = DEPTH - 4,
  parameter int    AEMPTY_TH  = DEF_AEMPTY_TH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [clog2(DEPTH+1)-1:0]    count,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int CW = clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;   // written but not yet read
  logic [1:0]            vld_pipe_q, vld_pipe_d; // [0] raddr loaded, [1] dout valid
  logic [OB_DEPTH-1:0][DATA_WIDTH-1:0] ob_q, ob_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic                  af_q, af_d, ae_q, ae_d;

  logic                  push, pop, issue, arrive;
  logic [2:0]            outst;
  logic [DATA_WIDTH-1:0] ram_dout;

  always_comb begin
    push   = clk_en & s_valid & s_ready_q;
    pop    = clk_en & m_valid_q & m_ready;
    arrive = clk_en & vld_pipe_q[1];
    // Words already committed to the output queue (in flight + held).
    outst  = {2'b0, vld_pipe_q[0]} + {2'b0, vld_pipe_q[1]} + {1'b0, ob_cnt_q};
    // A word written on the previous edge is the earliest one readable, so
    // the read side never touches an unwritten address.
    issue  = clk_en & (ram_cnt_q != '0) & ((outst - {2'b0, pop}) < 3'(OB_DEPTH));

    wptr_d = wptr_q;
    if (push) wptr_d = (wptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wptr_q + ADDR_WIDTH'(1);
    rptr_d = rptr_q;
    if (issue) rptr_d = (rptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rptr_q + ADDR_WIDTH'(1);

    count_d    = count_q + CW'(push) - CW'(pop);
    ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(issue);
    vld_pipe_d = clk_en ? {vld_pipe_q[0], issue} : vld_pipe_q;

    // Output queue: shift on pop, then append the arriving RAM word behind
    // whatever remains.
    ob_d     = ob_q;
    ob_cnt_d = ob_cnt_q;
    if (pop) begin
      for (int i = 0; i < OB_DEPTH - 1; i++) ob_d[i] = ob_q[i+1];
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    if (arrive) begin
      ob_d[ob_cnt_d] = ram_dout;
      ob_cnt_d       = ob_cnt_d + 2'd1;
    end

    s_ready_d = count_d < CW'(DEPTH);
    m_valid_d = ob_cnt_d != 2'd0;
    af_d      = count_d >= CW'(AFULL_TH);
    ae_d      = count_d <= CW'(AEMPTY_TH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ram_cnt_q  <= '0;
      vld_pipe_q <= '0;
      ob_q       <= '0;
      ob_cnt_q   <= '0;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      af_q       <= (AFULL_TH == 0);
      ae_q       <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ram_cnt_q  <= ram_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      ob_q       <= ob_d;
      ob_cnt_q   <= ob_cnt_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

  kernel3_gmem_m_axi_fifo_ram #(
    .MEM_STYLE  (MEM_STYLE),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .ce    (clk_en),
    .we    (push),
    .waddr (wptr_q),
    .din   (s_data),
    .rd_en (issue),
    .raddr (rptr_q),
    .dout  (ram_dout)
  );

  assign s_ready      = s_ready_q;
  assign m_valid      = m_valid_q;
  assign m_data       = ob_q[0];
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule
